cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle control unit that sits directly upstream of the 16-bit ALU. Fetches 16-bit instructions from a synchronous instruction memory and decodes them. Holds a 4-entry register file, drives ALU opcode/operands and writes back the ALU result. Sequences jumps, data-memory loads/stores over a req/ready handshake, and HALT.

## Interface
- ADDR_W, 8, instruction/data address width; PC wraps modulo 2^ADDR_W
- DATA_W, 16, data/register width (matches ALU)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_en  out  1  instruction read strobe
- imem_addr  out  ADDR_W  instruction address (= pc)
- imem_rdata  in  16  instruction, valid the cycle after imem_en
- alu_opcode  out  4  instr[15:12] of the current instruction register
- alu_operand0  out  DATA_W  reg[rd]
- alu_operand1  out  DATA_W  reg[rs] (opcodes 0-9) or zero-extended imm (10-15)
- alu_result  in  DATA_W  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  ADDR_W  imm field
- dmem_wdata  out  DATA_W  reg[rd] for store
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready
- dmem_ready  in  1  request completes this cycle
- pc  out  ADDR_W  current program counter
- halted  out  1  high in HALT state

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MULT, 4 SHR1, 6 AND, 7 OR, 8 XOR, 10 LDI, 11 JMP, 12 JMPZ, 13 STORE, 14 LOAD, 15 HALT. Opcodes 5 and 9 are treated as NOP.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: imem_en=1, imem_addr=pc, go to DECODE.
- DECODE: latch imem_rdata into the instruction register. If opcode is 15, go to HALT; otherwise go to EXECUTE.
- EXECUTE: latch alu_result into result_q.
  - For opcodes 1-4 and 6-8, also latch alu_zero into zflag.
  - Opcodes 13 and 14 go to MEM; all others go to WRITEBACK.
- MEM: hold dmem_req=1 with dmem_we/addr/wdata stable until dmem_ready=1.
  - A load latches dmem_rdata into result_q in the ready cycle.
  - Go to WRITEBACK the cycle after ready.
  - dmem_ready outside MEM is ignored.
- WRITEBACK:
  - Opcodes 1-4, 6-8, 10 and 14 write result_q to reg[rd]. Opcodes 0, 5, 9, 11, 12 and 13 write nothing.
  - pc update: JMP sets pc=imm. JMPZ sets pc=imm if zflag=1, else pc+1. All other opcodes set pc+1.
  - Go to FETCH.
- HALT: terminal; pc and registers frozen; leaves only on rst.
- zflag is updated only by ALU-class ops; LDI, LOAD, JMP, STORE and NOP preserve it.
- Arithmetic is computed in the ALU and truncated to DATA_W. MULT keeps the low 16 bits.

## Timing
- Reset values: pc=0, all regs=0, zflag=0, instruction register=0, result_q=0, state=FETCH. All outputs are 0, including halted=0, dmem_req=0 and imem_en=0, except imem_en=1 in the first post-reset cycle (FETCH).
- Latency:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Memory instruction: 5 + N cycles, where N = number of cycles dmem_ready stays low after MEM is entered.
  - HALT asserts halted 2 cycles after its FETCH.
- Handshake: dmem_req rises on MEM entry and falls the cycle after dmem_ready. It never deasserts before ready.
- ready in the first MEM cycle gives a 1-cycle MEM.
- PC wrap: pc+1 from 2^ADDR_W-1 gives 0.
- rst mid-operation (including during MEM) returns to the reset state next edge. dmem_req drops immediately and the pending access is abandoned.
- Register rd=rs is legal: operands are read before writeback.

## Test plan
- Reset: hold rst 2 cycles mid-program → pc=0, halted=0, dmem_req=0, imem_en=1 first cycle after release.
- Arithmetic: LDI r0,5; LDI r1,3; SUB r0,r1; ADD r2? (r2=r2+r0) → r0=2, r2=2, each instr 4 cycles, zflag=0 after SUB.
- Zero/branch: LDI r0,7; LDI r1,7; SUB r0,r1 (zflag=1); JMPZ 0x20 → pc=0x20. Repeat with r1=6 → pc=next.
- Memory: STORE r0→0x10 with ready delayed 3 cycles → dmem_req high exactly 4 cycles, we=1, wdata=r0. LOAD r3←0x10 with rdata=0xBEEF → r3=0xBEEF, zflag unchanged.
- Wrap/halt: JMP 0xFF; instr at 0xFF is NOP → next fetch addr 0x00. Opcode 15 → halted=1 permanently, no further imem_en until rst.
- Reset during MEM with ready held low → dmem_req=0 next cycle, no register written.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit feeding a 16-bit ALU: fetch, decode, execute, memory, writeback, halt.
// Latency: 4 cycles per ALU/jump instruction, 5+N for loads/stores (N = dmem_ready wait cycles).
// Backpressure: the MEM state holds dmem_req and its address/data stable until dmem_ready is seen.
module cpu_control_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   output logic [3:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_operand0,
   output logic [DATA_W-1:0] alu_operand1,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   // Opcode encodings used by the sequencer (the ALU decodes its own subset).
   localparam logic [3:0] OP_LDI   = 4'd10;
   localparam logic [3:0] OP_JMP   = 4'd11;
   localparam logic [3:0] OP_JMPZ  = 4'd12;
   localparam logic [3:0] OP_STORE = 4'd13;
   localparam logic [3:0] OP_LOAD  = 4'd14;
   localparam logic [3:0] OP_HALT  = 4'd15;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t state_q;
   state_t state_d;

   // Architectural and pipeline state.
   logic [15:0]       ir_q;
   logic [DATA_W-1:0] result_q;
   logic              zflag_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;
   logic [DATA_W-1:0] regs_q [4];

   // Instruction fields of the current instruction register.
   logic [3:0] opc;
   logic [1:0] rd;
   logic [1:0] rs;
   logic [7:0] imm;

   // Decoded instruction classes.
   logic is_alu_op;
   logic is_mem_op;
   logic is_store;
   logic writes_rd;
   logic uses_imm;

   assign opc = ir_q[15:12];
   assign rd  = ir_q[11:10];
   assign rs  = ir_q[9:8];
   assign imm = ir_q[7:0];

   // ALU-class ops are the only ones allowed to touch zflag; 5 and 9 are NOPs.
   assign is_alu_op = (opc == 4'd1) || (opc == 4'd2) || (opc == 4'd3) || (opc == 4'd4) ||
                      (opc == 4'd6) || (opc == 4'd7) || (opc == 4'd8);
   assign is_store  = (opc == OP_STORE);
   assign is_mem_op = is_store || (opc == OP_LOAD);
   assign writes_rd = is_alu_op || (opc == OP_LDI) || (opc == OP_LOAD);
   assign uses_imm  = (opc >= OP_LDI);

   // ALU and memory operand routing straight from the instruction register.
   assign alu_opcode   = opc;
   assign alu_operand0 = regs_q[rd];
   assign alu_operand1 = uses_imm ? DATA_W'(imm) : regs_q[rs];
   assign dmem_we      = dmem_req && is_store;
   assign dmem_addr    = ADDR_W'(imm);
   assign dmem_wdata   = regs_q[rd];
   assign imem_addr    = pc_q;
   assign pc           = pc_q;

   // Next pc: jumps take the immediate, everything else steps with natural wrap.
   always_comb begin
      pc_next = pc_q + ADDR_W'(1);
      if ((opc == OP_JMP) || ((opc == OP_JMPZ) && zflag_q)) begin
         pc_next = ADDR_W'(imm);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and state-decoded strobes.
   always_comb begin
      state_d  = state_q;
      imem_en  = 1'b0;
      dmem_req = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_en = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // HALT is recognised from the fetched word so it never reaches EXECUTE.
            state_d = (imem_rdata[15:12] == OP_HALT) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = is_mem_op ? S_MEM : S_WRITEBACK;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Datapath: instruction latch, result capture, flag, register file and pc updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q     <= '0;
         result_q <= '0;
         zflag_q  <= 1'b0;
         pc_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_DECODE: begin
               ir_q <= imem_rdata;
            end
            S_EXECUTE: begin
               result_q <= alu_result;
               if (is_alu_op) begin
                  zflag_q <= alu_zero;
               end
            end
            S_MEM: begin
               // Load data is only valid in the cycle the memory signals ready.
               if (dmem_ready && !is_store) begin
                  result_q <= dmem_rdata;
               end
            end
            S_WRITEBACK: begin
               if (writes_rd) begin
                  regs_q[rd] <= result_q;
               end
               pc_q <= pc_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a program table run one instruction at a time,
// with a behavioural ALU and data memory, plus hand-written halt and reset sequences.
module tb_cpu_control_unit;

   logic        clk;
   logic        rst;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_operand0;
   logic [15:0] alu_operand1;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic        dmem_req;
   logic        dmem_we;
   logic [7:0]  dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ready;
   logic [7:0]  pc;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   cpu_control_unit #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .alu_opcode   (alu_opcode),
      .alu_operand0 (alu_operand0),
      .alu_operand1 (alu_operand1),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ready   (dmem_ready),
      .pc           (pc),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unknown opcodes yield a marker value so stray writebacks show up.
   always_comb begin
      case (alu_opcode)
         4'd1:    alu_result = alu_operand0 + alu_operand1;
         4'd2:    alu_result = alu_operand0 - alu_operand1;
         4'd3:    alu_result = alu_operand0 * alu_operand1;
         4'd4:    alu_result = alu_operand0 >> 1;
         4'd6:    alu_result = alu_operand0 & alu_operand1;
         4'd7:    alu_result = alu_operand0 | alu_operand1;
         4'd8:    alu_result = alu_operand0 ^ alu_operand1;
         4'd10:   alu_result = alu_operand1;
         default: alu_result = 16'hDEAD;
      endcase
      alu_zero = (alu_result == 16'h0000);
   end

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  pc;
      logic [15:0] op0;
      logic [15:0] op1;
      logic [7:0]  nxt;
      int          cycles;
      int          reqs;
      int          delay;
      logic [15:0] rdata;
      bit          halt;
      bit          chk_ops;
   } step_t;

   step_t prog [$];

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic step_t mk_step(input logic [15:0] ins, input logic [7:0] at,
                                     input logic [15:0] op0, input logic [15:0] op1,
                                     input logic [7:0] nxt, input int cycles, input int reqs,
                                     input int delay, input logic [15:0] rdata);
      step_t s;
      s.instr   = ins;
      s.pc      = at;
      s.op0     = op0;
      s.op1     = op1;
      s.nxt     = nxt;
      s.cycles  = cycles;
      s.reqs    = reqs;
      s.delay   = delay;
      s.rdata   = rdata;
      s.halt    = 1'b0;
      s.chk_ops = 1'b1;
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one instruction starting at the negedge of its FETCH cycle and ends at the
   // negedge of the next FETCH (or of HALT). Data memory replies after s.delay wait cycles.
   task automatic run_step(input string tag, input step_t s);
      int cyc;
      int reqc;
      bit done;
      imem_rdata = s.instr;
      chk({tag, "_fetch_en"}, {31'd0, imem_en}, 32'd1);
      chk({tag, "_fetch_addr"}, {24'd0, imem_addr}, {24'd0, s.pc});
      cyc  = 0;
      reqc = 0;
      done = 1'b0;
      while (!done) begin
         if (cyc == 2 && s.chk_ops) begin
            chk({tag, "_opcode"}, {28'd0, alu_opcode}, {28'd0, s.instr[15:12]});
            chk({tag, "_op0"}, {16'd0, alu_operand0}, {16'd0, s.op0});
            chk({tag, "_op1"}, {16'd0, alu_operand1}, {16'd0, s.op1});
         end
         if (dmem_req) begin
            chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, (s.instr[15:12] == 4'd13)});
            chk({tag, "_daddr"}, {24'd0, dmem_addr}, {24'd0, s.instr[7:0]});
            if (s.instr[15:12] == 4'd13) begin
               chk({tag, "_wdata"}, {16'd0, dmem_wdata}, {16'd0, s.op0});
            end
            dmem_ready = (reqc == s.delay);
            dmem_rdata = (reqc == s.delay) ? s.rdata : 16'hBAD0;
            reqc++;
         end else begin
            // Ready is held high outside MEM; the unit must ignore it there.
            dmem_ready = 1'b1;
            dmem_rdata = 16'hBAD1;
         end
         @(negedge clk);
         cyc++;
         if (imem_en || halted || cyc >= 40) done = 1'b1;
      end
      dmem_ready = 1'b0;
      chk({tag, "_cycles"}, cyc, s.cycles);
      chk({tag, "_reqs"}, reqc, s.reqs);
      chk({tag, "_halted"}, {31'd0, halted}, {31'd0, s.halt});
      chk({tag, "_pc_next"}, {24'd0, pc}, {24'd0, s.nxt});
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step_t hs;
      rst        = 1'b1;
      imem_rdata = 16'h0000;
      dmem_rdata = 16'h0000;
      dmem_ready = 1'b0;

      //             instr                 pc     op0       op1       nxt    cyc req dly rdata
      prog.push_back(mk_step(mk(10,0,0,8'h05), 8'h00, 16'h0000, 16'h0005, 8'h01, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(10,1,0,8'h03), 8'h01, 16'h0000, 16'h0003, 8'h02, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(2,0,1,8'h00),  8'h02, 16'h0005, 16'h0003, 8'h03, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(1,2,0,8'h00),  8'h03, 16'h0000, 16'h0002, 8'h04, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(12,0,0,8'h40), 8'h04, 16'h0002, 16'h0040, 8'h05, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(8,2,2,8'h00),  8'h05, 16'h0002, 16'h0002, 8'h06, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(10,0,0,8'h07), 8'h06, 16'h0002, 16'h0007, 8'h07, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(10,1,0,8'h07), 8'h07, 16'h0003, 16'h0007, 8'h08, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(2,0,1,8'h00),  8'h08, 16'h0007, 16'h0007, 8'h09, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(10,3,0,8'h09), 8'h09, 16'h0000, 16'h0009, 8'h0A, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(12,0,0,8'h20), 8'h0A, 16'h0000, 16'h0020, 8'h20, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(13,1,0,8'h10), 8'h20, 16'h0007, 16'h0010, 8'h21, 8, 4, 3, 16'h0));
      prog.push_back(mk_step(mk(14,3,0,8'h10), 8'h21, 16'h0009, 16'h0010, 8'h22, 5, 1, 0, 16'hBEEF));
      prog.push_back(mk_step(mk(12,0,0,8'h30), 8'h22, 16'h0000, 16'h0030, 8'h30, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(3,3,3,8'h00),  8'h30, 16'hBEEF, 16'hBEEF, 8'h31, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(4,3,0,8'h00),  8'h31, 16'hA321, 16'h0000, 8'h32, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(7,3,1,8'h00),  8'h32, 16'h5190, 16'h0007, 8'h33, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(11,0,0,8'hFF), 8'h33, 16'h0000, 16'h00FF, 8'hFF, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(0,3,2,8'h00),  8'hFF, 16'h5197, 16'h0000, 8'h00, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(12,0,0,8'h50), 8'h00, 16'h0000, 16'h0050, 8'h01, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(5,1,1,8'h00),  8'h01, 16'h0007, 16'h0007, 8'h02, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(9,1,0,8'h00),  8'h02, 16'h0007, 16'h0000, 8'h03, 4, 0, 0, 16'h0));
      prog.push_back(mk_step(mk(6,1,1,8'h00),  8'h03, 16'h0007, 16'h0007, 8'h04, 4, 0, 0, 16'h0));
      hs = mk_step(mk(15,0,0,8'h00), 8'h04, 16'h0, 16'h0, 8'h04, 2, 0, 0, 16'h0);
      hs.halt    = 1'b1;
      hs.chk_ops = 1'b0;
      prog.push_back(hs);

      // Reset state as seen in the first cycle after release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_imem_en", {31'd0, imem_en}, 32'd1);
      chk("rst_pc", {24'd0, pc}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("rst_op0", {16'd0, alu_operand0}, 32'd0);
      chk("rst_op1", {16'd0, alu_operand1}, 32'd0);

      for (int i = 0; i < prog.size(); i++) begin
         run_step($sformatf("step%0d", i), prog[i]);
      end

      // HALT is terminal: no fetches, pc frozen.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("halt_hold%0d_halted", i), {31'd0, halted}, 32'd1);
         chk($sformatf("halt_hold%0d_imem_en", i), {31'd0, imem_en}, 32'd0);
         chk($sformatf("halt_hold%0d_pc", i), {24'd0, pc}, 32'd4);
      end

      // Two-cycle reset out of HALT.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst2_pc", {24'd0, pc}, 32'd0);
      chk("rst2_halted", {31'd0, halted}, 32'd0);
      chk("rst2_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst2_imem_en", {31'd0, imem_en}, 32'd1);

      // LDI r2,0x77 then a store stalled in MEM that gets reset away.
      run_step("pre_mem", mk_step(mk(10,2,0,8'h77), 8'h00, 16'h0000, 16'h0077, 8'h01, 4, 0, 0, 16'h0));
      imem_rdata = mk(13,2,0,8'h10);
      dmem_ready = 1'b0;
      chk("mrst_fetch_en", {31'd0, imem_en}, 32'd1);
      repeat (3) @(negedge clk);
      chk("mrst_req_on", {31'd0, dmem_req}, 32'd1);
      chk("mrst_wdata", {16'd0, dmem_wdata}, 32'h77);
      repeat (2) @(negedge clk);
      chk("mrst_req_held", {31'd0, dmem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_req_off", {31'd0, dmem_req}, 32'd0);
      chk("mrst_pc", {24'd0, pc}, 32'd0);
      chk("mrst_imem_en", {31'd0, imem_en}, 32'd1);
      run_step("post_mem", mk_step(mk(1,2,2,8'h00), 8'h00, 16'h0000, 16'h0000, 8'h01, 4, 0, 0, 16'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
